// File: rtl/regfile8x4.sv
// Register file with two combinational read ports and one write port.
// Register 0 is a hardwired zero source; optional write-to-read forwarding.
module regfile8x4 #(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 8,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  // Index 0 has no storage; reads of address 0 are forced to zero below.
  logic [WIDTH-1:0] regs [1:NREGS-1];

  logic write_valid;
  logic hit1;
  logic hit2;

  assign write_valid = we3 && !reset && (wa3 != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_valid) begin
      regs[wa3] <= wd3;
    end
  end

  // Forwarding only applies to a write that will actually land on this edge.
  assign hit1 = (BYPASS != 0) && write_valid && (wa3 == ra1);
  assign hit2 = (BYPASS != 0) && write_valid && (wa3 == ra2);

  assign rd1 = (ra1 == '0) ? '0 : (hit1 ? wd3 : regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : (hit2 ? wd3 : regs[ra2]);

endmodule

// File: tb/tb_regfile8x4.sv
// Bench for regfile8x4: one instance without and one with forwarding, shared inputs,
// checked every cycle against an array model plus directed literal expectations.
module tb_regfile8x4;

  logic       clk = 1'b0;
  logic       reset;
  logic       we3;
  logic [2:0] wa3;
  logic [3:0] wd3;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic [3:0] rd1_a;
  logic [3:0] rd2_a;
  logic [3:0] rd1_b;
  logic [3:0] rd2_b;

  int checks   = 0;
  int failures = 0;

  logic [3:0] mem [8];
  bit         model_valid = 1'b0;

  always #5 clk = ~clk;

  regfile8x4 #(.WIDTH(4), .NREGS(8), .BYPASS(0)) dut_plain (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a)
  );

  regfile8x4 #(.WIDTH(4), .NREGS(8), .BYPASS(1)) dut_fwd (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b)
  );

  task automatic check_output(input string name, input logic [3:0] actual,
                              input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic w, input logic [2:0] wa,
                                input logic [3:0] wd, input logic [2:0] a1,
                                input logic [2:0] a2);
    reset = r;
    we3   = w;
    wa3   = wa;
    wd3   = wd;
    ra1   = a1;
    ra2   = a2;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Reference state: what each register holds after the edge, from the write/reset rules.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] = 4'h0;
      model_valid = 1'b1;
    end else if (we3 && wa3 != 3'd0) begin
      mem[wa3] = wd3;
    end
  end

  function automatic logic [3:0] stored(input logic [2:0] a);
    return (a == 3'd0) ? 4'h0 : mem[a];
  endfunction

  function automatic logic [3:0] forwarded(input logic [2:0] a);
    if (we3 && !reset && wa3 != 3'd0 && wa3 == a) return wd3;
    return stored(a);
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      check_output("model_rd1_plain", rd1_a, stored(ra1));
      check_output("model_rd2_plain", rd2_a, stored(ra2));
      check_output("model_rd1_fwd", rd1_b, forwarded(ra1));
      check_output("model_rd2_fwd", rd2_b, forwarded(ra2));
    end
  end

  initial begin
    apply_stimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("r0_prereset_plain", rd1_a, 4'h0);
    check_output("r0_prereset_fwd", rd2_b, 4'h0);
    next_cycle;

    // Fill r1..r7 with F, then a single reset cycle must clear everything.
    for (int a = 1; a < 8; a++) begin
      apply_stimulus(0, 1, 3'(a), 4'hF, 0, 0);
      next_cycle;
    end
    apply_stimulus(1, 0, 0, 0, 0, 0);
    next_cycle;
    for (int a = 0; a < 8; a++) begin
      apply_stimulus(0, 0, 0, 0, 3'(a), 3'(7 - a));
      @(negedge clk);
      check_output("reset_clear_rd1", rd1_a, 4'h0);
      check_output("reset_clear_rd2", rd2_a, 4'h0);
      check_output("reset_clear_fwd", rd1_b, 4'h0);
      next_cycle;
    end

    // Reset beats a write on the same edge.
    apply_stimulus(0, 1, 4, 4'h3, 4, 4);
    next_cycle;
    apply_stimulus(1, 1, 4, 4'hC, 4, 4);
    @(negedge clk);
    check_output("prio_before_plain", rd1_a, 4'h3);
    check_output("prio_before_fwd", rd1_b, 4'h3);
    next_cycle;
    apply_stimulus(0, 0, 0, 0, 4, 4);
    @(negedge clk);
    check_output("prio_after_plain", rd1_a, 4'h0);
    check_output("prio_after_fwd", rd2_b, 4'h0);
    next_cycle;

    apply_stimulus(0, 1, 3, 4'hA, 0, 0);
    next_cycle;
    apply_stimulus(0, 1, 5, 4'h6, 0, 0);
    next_cycle;
    apply_stimulus(0, 0, 0, 0, 3, 5);
    @(negedge clk);
    check_output("basic_r3", rd1_a, 4'hA);
    check_output("basic_r5", rd2_a, 4'h6);
    next_cycle;
    apply_stimulus(0, 0, 0, 0, 5, 5);
    @(negedge clk);
    check_output("same_addr_rd1", rd1_a, 4'h6);
    check_output("same_addr_rd2", rd2_a, 4'h6);
    next_cycle;

    // A write to address 0 must neither be stored nor forwarded.
    apply_stimulus(0, 1, 0, 4'hF, 0, 0);
    @(negedge clk);
    check_output("zero_write_plain", rd1_a, 4'h0);
    check_output("zero_write_fwd", rd1_b, 4'h0);
    next_cycle;
    for (int a = 0; a < 8; a++) begin
      apply_stimulus(0, 0, 0, 0, 3'(a), 3'(a));
      @(negedge clk);
      check_output("zero_write_others", rd1_a,
                   (a == 3) ? 4'hA : ((a == 5) ? 4'h6 : 4'h0));
      next_cycle;
    end

    apply_stimulus(0, 1, 2, 4'h1, 0, 0);
    next_cycle;
    apply_stimulus(0, 1, 2, 4'h9, 2, 2);
    @(negedge clk);
    check_output("rw_same_cycle_plain", rd1_a, 4'h1);
    check_output("rw_same_cycle_plain_rd2", rd2_a, 4'h1);
    check_output("rw_same_cycle_fwd", rd1_b, 4'h9);
    next_cycle;
    apply_stimulus(0, 0, 0, 0, 2, 2);
    @(negedge clk);
    check_output("rw_next_cycle_plain", rd1_a, 4'h9);
    check_output("rw_next_cycle_fwd", rd1_b, 4'h9);
    next_cycle;

    for (int n = 0; n < 1000; n++) begin
      apply_stimulus(($urandom_range(31) == 0), 1'($urandom_range(1)),
                     3'($urandom_range(7)), 4'($urandom_range(15)),
                     3'($urandom_range(7)), 3'($urandom_range(7)));
      next_cycle;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
